cla_adder_pipe: RTL and testbench

//  Parametrised two-stage pipelined carry-lookahead adder; next generation of the TTL 4-group lookahead generator.

---
 rtl/cla_pkg.sv | 56 +++++
 rtl/cla_lookahead_unit.sv | 28 ++
 rtl/cla_adder_pipe.sv | 156 +++++++++++++++
 tb/tb_cla_adder_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and carry-lookahead helper functions for the pipelined CLA adder.
// Vectors are sized to the largest supported configuration; callers pass the active count.
package cla_pkg;

  localparam int unsigned MAX_GROUP = 16;
  localparam int unsigned MAX_NGRP  = 32;
  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_GROUP = 4;
  localparam int unsigned DEF_NGRP  = DEF_WIDTH / DEF_GROUP;

  typedef logic [MAX_NGRP-1:0]  grp_vec_t;
  typedef logic [MAX_NGRP:0]    carry_vec_t;
  typedef logic [MAX_GROUP-1:0] grp_bits_t;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Group propagate/generate over the low n bits; G ripples from the LSB upward.
  function automatic pg_t grp_pg(input grp_bits_t a, input grp_bits_t b, input int unsigned n);
    pg_t r;
    r.p = 1'b1;
    r.g = 1'b0;
    for (int unsigned i = 0; i < MAX_GROUP; i++) begin
      if (i < n) begin
        r.g = (a[i] & b[i]) | ((a[i] ^ b[i]) & r.g);
        r.p = r.p & (a[i] ^ b[i]);
      end
    end
    return r;
  endfunction

  // Flattened sum-of-products carries: c[k+1] = G[k] | P[k]G[k-1] | ... | P[k..0]cin.
  function automatic carry_vec_t lookahead(input grp_vec_t p, input grp_vec_t g,
                                           input logic cin, input int unsigned n);
    carry_vec_t c;
    logic       term;
    logic       pacc;
    c    = '0;
    c[0] = cin;
    for (int unsigned k = 0; k < MAX_NGRP; k++) begin
      if (k < n) begin
        term = g[k];
        pacc = p[k];
        for (int j = int'(k) - 1; j >= 0; j--) begin
          term = term | (pacc & g[j]);
          pacc = pacc & p[j];
        end
        c[k+1] = term | (pacc & cin);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_lookahead_unit.sv
// Single-level lookahead generator: group P/G plus cin in, group carries and word P/G out.
module cla_lookahead_unit
  import cla_pkg::*;
#(
  parameter int unsigned NGRP = DEF_NGRP
) (
  input  logic [NGRP-1:0] grp_p,
  input  logic [NGRP-1:0] grp_g,
  input  logic            cin,
  output logic [NGRP:0]   carry_c,
  output logic            word_p_c,
  output logic            word_g_c
);

  carry_vec_t carry_full_c;
  carry_vec_t gen_full_c;
  logic       unused_c;

  assign carry_full_c = lookahead(grp_vec_t'(grp_p), grp_vec_t'(grp_g), cin, NGRP);
  // Word generate is the top carry with cin forced low, so it cascades independently of cin.
  assign gen_full_c   = lookahead(grp_vec_t'(grp_p), grp_vec_t'(grp_g), 1'b0, NGRP);

  assign carry_c  = carry_full_c[NGRP:0];
  assign word_g_c = gen_full_c[NGRP];
  assign word_p_c = &grp_p;
  assign unused_c = ^{carry_full_c, gen_full_c};

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
// Optional zero/overflow flags are built when CLA_FLAGS_EN is defined.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_p,
  output logic             out_g
`ifdef CLA_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_ovf
`endif
);

  localparam int unsigned NGRP = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP");
  end
  if ((GROUP > MAX_GROUP) || (NGRP > MAX_NGRP)) begin : g_bad_size
    $error("cla_adder_pipe: GROUP or WIDTH/GROUP exceeds package limits");
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [NGRP-1:0]  s1_gp;
  logic [NGRP-1:0]  s1_gg;

  logic             adv2_c;
  logic             ready_c;
  logic             fire_c;
  logic [NGRP-1:0]  grp_p_c;
  logic [NGRP-1:0]  grp_g_c;
  logic [NGRP:0]    carry_c;
  logic             word_p_c;
  logic             word_g_c;
  logic [WIDTH-1:0] bit_p_c;
  logic [WIDTH-1:0] bit_cin_c;
  logic [WIDTH-1:0] sum_c;

  // Handshake: ready depends only on pipeline state and out_ready.
  assign adv2_c   = !out_valid | out_ready;
  assign ready_c  = !s1_valid | adv2_c;
  assign in_ready = reset_n & ready_c;
  assign fire_c   = in_valid & ready_c;

  // Stage 1 combinational: per-group P/G from the incoming operands.
  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    pg_t pg_c;
    assign pg_c = grp_pg(grp_bits_t'(in_a[k*GROUP +: GROUP]),
                         grp_bits_t'(in_b[k*GROUP +: GROUP]), GROUP);
    assign grp_p_c[k] = pg_c.p;
    assign grp_g_c[k] = pg_c.g;
  end

  cla_lookahead_unit #(.NGRP(NGRP)) u_lookahead (
    .grp_p    (s1_gp),
    .grp_g    (s1_gg),
    .cin      (s1_cin),
    .carry_c  (carry_c),
    .word_p_c (word_p_c),
    .word_g_c (word_g_c)
  );

  // Stage 2 combinational: short ripple inside each group seeded by the lookahead carry.
  assign bit_p_c = s1_a ^ s1_b;
  for (genvar k = 0; k < NGRP; k++) begin : g_sum
    for (genvar i = 0; i < GROUP; i++) begin : g_bit
      localparam int unsigned IDX = k * GROUP + i;
      if (i == 0) begin : g_base
        assign bit_cin_c[IDX] = carry_c[k];
      end else begin : g_rip
        assign bit_cin_c[IDX] = (s1_a[IDX-1] & s1_b[IDX-1]) | (bit_p_c[IDX-1] & bit_cin_c[IDX-1]);
      end
      assign sum_c[IDX] = bit_p_c[IDX] ^ bit_cin_c[IDX];
    end
  end

  // Stage 1 register: payload loads on any accept; flush only kills the valid bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_gp    <= '0;
      s1_gg    <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (ready_c) begin
        s1_valid <= in_valid;
      end
      if (fire_c) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_cin <= in_cin;
        s1_gp  <= grp_p_c;
        s1_gg  <= grp_g_c;
      end
    end
  end

  // Stage 2 register: held while stalled so the presented result stays stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_p     <= 1'b0;
      out_g     <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (adv2_c) begin
        out_valid <= s1_valid;
      end
      if (adv2_c && s1_valid) begin
        out_sum  <= sum_c;
        out_cout <= carry_c[NGRP];
        out_p    <= word_p_c;
        out_g    <= word_g_c;
      end
    end
  end

`ifdef CLA_FLAGS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (adv2_c && s1_valid) begin
      out_zero <= (sum_c == '0);
      out_ovf  <= (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum_c[WIDTH-1] != s1_a[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: 32/4 and 16/8 instances checked against an arithmetic reference.
`timescale 1ns/1ps
module tb_cla_adder_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_cin = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;

  logic        in_ready, out_valid, out_cout, out_p, out_g;
  logic [31:0] out_sum;
  logic        in_ready16, out_valid16, out_cout16, out_p16, out_g16;
  logic [15:0] out_sum16;
`ifdef CLA_FLAGS_EN
  logic        out_zero, out_ovf, out_zero16, out_ovf16;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        p;
    logic        g;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(32), .GROUP(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_p(out_p), .out_g(out_g)
`ifdef CLA_FLAGS_EN
    , .out_zero(out_zero), .out_ovf(out_ovf)
`endif
  );

  cla_adder_pipe #(.WIDTH(16), .GROUP(8)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_sum(out_sum16), .out_cout(out_cout16), .out_p(out_p16), .out_g(out_g16)
`ifdef CLA_FLAGS_EN
    , .out_zero(out_zero16), .out_ovf(out_ovf16)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result from plain arithmetic at width w (32 or 16).
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input int w);
    exp_t        e;
    logic [31:0] mask;
    logic [32:0] full;
    logic [32:0] nocin;
    mask  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    a     = a & mask;
    b     = b & mask;
    full  = 33'(a) + 33'(b) + 33'(cin);
    nocin = 33'(a) + 33'(b);
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    e.g    = nocin[w];
    e.p    = &((a ^ b) | ~mask);
    e.zero = (e.sum == 32'h0);
    e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    return e;
  endfunction

  // Compare outputs to the head of the expected queue, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      q32.delete();
      q16.delete();
    end else begin
      if (out_valid) begin
        if (q32.size() == 0) chk("w32 spurious valid", 32'(out_valid), 32'h0);
        else begin
          chk("w32 sum", out_sum, q32[0].sum);
          chk("w32 cout", 32'(out_cout), 32'(q32[0].cout));
          chk("w32 p", 32'(out_p), 32'(q32[0].p));
          chk("w32 g", 32'(out_g), 32'(q32[0].g));
`ifdef CLA_FLAGS_EN
          chk("w32 zero", 32'(out_zero), 32'(q32[0].zero));
          chk("w32 ovf", 32'(out_ovf), 32'(q32[0].ovf));
`endif
        end
      end
      if (out_valid16) begin
        if (q16.size() == 0) chk("w16 spurious valid", 32'(out_valid16), 32'h0);
        else begin
          chk("w16 sum", 32'(out_sum16), q16[0].sum);
          chk("w16 cout", 32'(out_cout16), 32'(q16[0].cout));
          chk("w16 p", 32'(out_p16), 32'(q16[0].p));
          chk("w16 g", 32'(out_g16), 32'(q16[0].g));
`ifdef CLA_FLAGS_EN
          chk("w16 zero", 32'(out_zero16), 32'(q16[0].zero));
          chk("w16 ovf", 32'(out_ovf16), 32'(q16[0].ovf));
`endif
        end
      end
      if (flush) begin
        q32.delete();
        q16.delete();
      end else begin
        if (out_valid && out_ready && q32.size() != 0) void'(q32.pop_front());
        if (out_valid16 && out_ready && q16.size() != 0) void'(q16.pop_front());
        if (in_valid && in_ready) q32.push_back(model(in_a, in_b, in_cin, 32));
        if (in_valid && in_ready16) q16.push_back(model(in_a, in_b, in_cin, 16));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_valid = 1'b1;
  endtask

  // One beat into an empty pipe with out_ready=1: checks 2-cycle latency and literal results.
  task automatic send_check(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic [31:0] es, input logic ec,
                            input logic ep, input logic eg, input logic ez, input logic eo);
    exp_t m;
    m = model(a, b, cin, 32);
    chk({name, " model zero"}, 32'(m.zero), 32'(ez));
    chk({name, " model ovf"}, 32'(m.ovf), 32'(eo));
    chk({name, " ready"}, 32'(in_ready), 32'h1);
    drive(a, b, cin);
    tick();
    in_valid = 1'b0;
    chk({name, " lat1 valid"}, 32'(out_valid), 32'h0);
    tick();
    chk({name, " lat2 valid"}, 32'(out_valid), 32'h1);
    chk({name, " sum"}, out_sum, es);
    chk({name, " cout"}, 32'(out_cout), 32'(ec));
    chk({name, " p"}, 32'(out_p), 32'(ep));
    chk({name, " g"}, 32'(out_g), 32'(eg));
`ifdef CLA_FLAGS_EN
    chk({name, " zero"}, 32'(out_zero), 32'(ez));
    chk({name, " ovf"}, 32'(out_ovf), 32'(eo));
`endif
    tick();
  endtask

  initial begin
    logic [9:0] vmask;

    // Reset state
    repeat (2) tick();
    chk("rst valid", 32'(out_valid), 32'h0);
    chk("rst sum", out_sum, 32'h0);
    chk("rst cout/p/g", 32'({out_cout, out_p, out_g}), 32'h0);
    chk("rst in_ready", 32'(in_ready), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'h1);
    tick();

    // Directed literal vectors
    send_check("t1 wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_check("t2 prop", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_check("t3 ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_check("t3b cin", 32'h0, 32'h0, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back 8 beats
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive(32'h1111_1111 * 32'(k + 1), 32'hF000_000F + 32'(k * 977), k[0]);
      else in_valid = 1'b0;
      tick();
      vmask[k] = out_valid;
    end
    chk("t4 valid pattern", 32'(vmask), 32'h1FE);
    chk("t4 drained", 32'(q32.size()), 32'h0);

    // Stall with 3 beats
    out_ready = 1'b0;
    drive(32'h10, 32'h20, 1'b0);
    tick();
    chk("t5 ready after 1", 32'(in_ready), 32'h1);
    drive(32'h1234_0000, 32'h0000_4321, 1'b1);
    tick();
    chk("t5 ready after 2", 32'(in_ready), 32'h0);
    drive(32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5 stall ready", 32'(in_ready), 32'h0);
      chk("t5 stall sum", out_sum, 32'h30);
    end
    out_ready = 1'b1;
    #1;
    chk("t5 release ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t5 drained", 32'(q32.size()), 32'h0);

    // Flush with two beats in flight
    out_ready = 1'b0;
    drive(32'h5, 32'h6, 1'b0);
    tick();
    drive(32'h7, 32'h8, 1'b0);
    tick();
    chk("t6 pre-flush valid", 32'(out_valid), 32'h1);
    flush = 1'b1;
    drive(32'h9, 32'hA, 1'b0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("t6 flushed valid", 32'(out_valid), 32'h0);
    tick();
    chk("t6 still empty", 32'(out_valid), 32'h0);
    send_check("t6 post-flush", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream
    drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    tick();
    drive(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    tick();
    #1 reset_n = 1'b0;
    #1;
    chk("t6 rst valid", 32'(out_valid), 32'h0);
    chk("t6 rst sum", out_sum, 32'h0);
    chk("t6 rst cout", 32'(out_cout), 32'h0);
    chk("t6 rst ready", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    send_check("t6 post-rst", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // Random traffic with random backpressure on both widths
    for (int k = 0; k < 400; k++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("rand drained w32", 32'(q32.size()), 32'h0);
    chk("rand drained w16", 32'(q16.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
